// File: rtl/uart_tx_pin.sv
// 8N1 UART transmitter with a one-byte holding register and a registered output pin.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame instead of one.
module uart_tx_pin #(
  parameter int CLKS_PER_BIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       wr,
  output logic       ready,
  output logic       busy,
  output logic       pin
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic             pin_q, pin_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             bit_end;

  assign bit_end = (div_q == DIV_MAX);
  assign ready   = ~hold_full_q;
  assign busy    = hold_full_q | (state_q != IDLE);
  assign pin     = pin_q;

  always_comb begin
    state_d     = state_q;
    pin_d       = pin_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    div_d       = div_q;
    bit_d       = bit_q;

    // Accept only while empty, so it can never coincide with the hand-off below.
    if (wr && !hold_full_q) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        div_d = '0;
        bit_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = START;
          pin_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          pin_d   = shift_q[0];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            pin_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            pin_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          div_d = '0;
          // bit_q counts stop bits here; a queued byte chains straight into START.
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 3'd1;
          end else begin
            bit_d = '0;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = START;
              pin_d       = 1'b0;
            end else begin
              state_d = IDLE;
              pin_d   = 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pin_q       <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_pin.sv
// Scoreboard bench for uart_tx_pin: a frame-schedule model predicts ready/busy/idle
// and each frame's byte and start cycle; a line monitor decodes frames off the pin.
module tb_uart_tx_pin;

  localparam int CPB = 64;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int SLOTS = 9 + STOP_BITS;
  localparam int FRAME = SLOTS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, busy, pin;

  uart_tx_pin #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .data(data), .wr(wr),
    .ready(ready), .busy(busy), .pin(pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;
  exp_t sb[$];

  // Frame schedule in absolute cycle numbers.
  int  cur_end = -1000;
  int  hold_free = -1000;
  int  busy_since = 0;
  int  chain_start = 0;
  bit  model_en = 1'b0;

  function automatic bit m_ready(int c);
    return c >= hold_free;
  endfunction

  function automatic bit m_busy(int c);
    return (c >= busy_since) && (c <= cur_end);
  endfunction

  function automatic bit m_pin_idle(int c);
    return (c > cur_end) || (c < chain_start);
  endfunction

  task automatic apply_accept(input int c, input logic [7:0] d);
    int start;
    exp_t e;
    start = (c + 2 > cur_end + 1) ? c + 2 : cur_end + 1;
    if (!m_busy(c)) busy_since = c + 1;
    if (start > cur_end + 1) chain_start = start;
    hold_free = start;
    cur_end   = start + FRAME - 1;
    e.b = d;
    e.start = start;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    cur_end     = -1000;
    hold_free   = -1000;
    busy_since  = 0;
    chain_start = 0;
    sb.delete();
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [7:0] d);
    int c;
    bit acc;
    @(negedge clk);
    wr = w;
    data = d;
    c = cyc;
    acc = w && m_ready(c);
    @(posedge clk);
    if (acc) apply_accept(c, d);
  endtask

  task automatic drain();
    int n = 0;
    while (cyc <= cur_end + 2 && n < 5000) begin
      drive(1'b0, 8'h00);
      n++;
    end
    if (n >= 5000) check_int("drain_timeout", n, 0);
  endtask

  // Per-cycle handshake and idle-line checks.
  always @(negedge clk) begin
    if (model_en && !rst) begin
      check_bit("ready", ready, m_ready(cyc));
      check_bit("busy", busy, m_busy(cyc));
      if (m_pin_idle(cyc)) check_bit("pin_idle", pin, 1'b1);
    end
  end

  // Line monitor: captures a whole frame after a falling start edge, then scores it.
  logic samp [0:FRAME-1];
  bit   mon_act = 1'b0;
  int   mon_n = 0;
  int   mon_start = 0;

  task automatic finish_frame();
    bit         shape_ok;
    logic [7:0] got;
    logic       v;
    exp_t       e;
    shape_ok = 1'b1;
    got = 8'h00;
    for (int k = 0; k < SLOTS; k++) begin
      v = samp[k*CPB];
      for (int j = 1; j < CPB; j++)
        if (samp[k*CPB+j] !== v) shape_ok = 1'b0;
      if (k == 0) begin
        if (v !== 1'b0) shape_ok = 1'b0;
      end else if (k <= 8) begin
        got[k-1] = v;
      end else if (v !== 1'b1) begin
        shape_ok = 1'b0;
      end
    end
    check_bit("frame_shape", shape_ok, 1'b1);
    if (sb.size() == 0) begin
      check_int("unexpected_frame_start", mon_start, -1);
    end else begin
      e = sb.pop_front();
      check_int("frame_byte", int'(got), int'(e.b));
      check_int("frame_start_cycle", mon_start, e.start);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (mon_act) begin
      samp[mon_n] = pin;
      mon_n++;
      if (mon_n == FRAME) begin
        mon_act = 1'b0;
        finish_frame();
      end
    end else if (pin === 1'b0) begin
      mon_act   = 1'b1;
      mon_start = cyc;
      samp[0]   = pin;
      mon_n     = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    repeat (2) @(negedge clk);
    check_bit("reset_pin", pin, 1'b1);
    check_bit("reset_ready", ready, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    model_en = 1'b1;

    // Long idle: line must stay high, nothing pending.
    repeat (1000) drive(1'b0, 8'h00);

    // Single byte from idle.
    drive(1'b1, 8'hA5);
    drain();

    // Second byte queued while the first is in its data bits: no gap between frames.
    drive(1'b1, 8'h00);
    repeat (CPB * 3) drive(1'b0, 8'h00);
    drive(1'b1, 8'hFF);
    drain();

    // Continuous write strobe with changing data: only bytes seen while ready count.
    repeat (3 * FRAME) drive(1'b1, 8'($urandom));
    drain();

    // Reset in the middle of data bit 3 with a byte also waiting in the holding register.
    drive(1'b1, 8'($urandom));
    s = cur_end - FRAME + 1;
    repeat (CPB) drive(1'b0, 8'h00);
    drive(1'b1, 8'($urandom));
    while (cyc < s + CPB * 4 + CPB / 2) drive(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_bit("rst_mid_pin", pin, 1'b1);
    check_bit("rst_mid_ready", ready, 1'b1);
    check_bit("rst_mid_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 8'h3C);
    drain();

    // Back-to-back 0x55 pair.
    drive(1'b1, 8'h55);
    repeat (5) drive(1'b0, 8'h00);
    drive(1'b1, 8'h55);
    drain();

    // Random sparse traffic.
    repeat (8000) drive($urandom_range(0, 99) < 3, 8'($urandom));
    drain();

    check_int("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
